// File: rtl/seq_divider_param.sv
// =============================================================================
// Module      : seq_divider_param
// Description : Multi-cycle restoring divider, W-bit signed/unsigned, with
//               valid/ready handshakes, divide-by-zero and overflow flags.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module seq_divider_param #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         signed_mode,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] C_LAST = CW'(W - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CALC = 3'd1;
    localparam logic [2:0] S_FIX  = 3'd2;
    localparam logic [2:0] S_DZ   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W:0]    r_p;
    logic [W-1:0]  r_dvd;
    logic          r_neg_q;
    logic          r_neg_r;
    logic          r_dz_pend;
    logic          r_ovf_pend;
    logic [W-1:0]  r_quot;
    logic [W-1:0]  r_rem;
    logic          r_dbz;
    logic          r_ovf;

    logic          w_dvd_neg;
    logic          w_dvs_neg;
    logic [W-1:0]  w_dvd_mag;
    logic [W-1:0]  w_dvs_mag;
    logic [W+1:0]  w_shift;
    logic [W+1:0]  w_diff;
    logic          w_fits;

    assign w_dvd_neg = signed_mode & dividend[W-1];
    assign w_dvs_neg = signed_mode & divisor[W-1];
    // W-bit unsigned magnitude keeps |-2^(W-1)| representable
    assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag = w_dvs_neg ? -divisor  : divisor;

    assign w_shift = {r_p, r_a[W-1]};
    assign w_diff  = w_shift - {2'b00, r_b};
    assign w_fits  = ~w_diff[W+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (ena) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_next = (divisor == '0) ? S_DZ : S_CALC;
            S_CALC: if (r_cnt == '0) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            // DZ primes the datapath with the fixed result; FIX registers it
            S_DZ:   w_next = S_FIX;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_p        <= '0;
            r_dvd      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dz_pend  <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_dbz      <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (ena) begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= w_dvd_mag;
                        r_b        <= w_dvs_mag;
                        r_p        <= '0;
                        r_dvd      <= dividend;
                        r_neg_q    <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r    <= w_dvd_neg;
                        r_cnt      <= C_LAST;
                        r_dz_pend  <= (divisor == '0);
                        r_ovf_pend <= signed_mode & (dividend == {1'b1, {(W-1){1'b0}}})
                                      & (divisor == '1);
                        r_dbz      <= 1'b0;
                        r_ovf      <= 1'b0;
                    end
                end
                S_CALC: begin
                    // r_a shifts dividend bits out and quotient bits in
                    r_p   <= w_fits ? w_diff[W:0] : w_shift[W:0];
                    r_a   <= {r_a[W-2:0], w_fits};
                    r_cnt <= r_cnt - 1'b1;
                end
                S_DZ: begin
                    r_a     <= '1;
                    r_p     <= {1'b0, r_dvd};
                    r_neg_q <= 1'b0;
                    r_neg_r <= 1'b0;
                end
                S_FIX: begin
                    r_quot <= r_neg_q ? -r_a : r_a;
                    r_rem  <= r_neg_r ? -r_p[W-1:0] : r_p[W-1:0];
                    r_dbz  <= r_dz_pend;
                    r_ovf  <= r_ovf_pend;
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider_param.sv
// =============================================================================
// Module      : tb_seq_divider_param
// Description : Scoreboard bench for seq_divider_param at W=8 and W=16.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_seq_divider_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        in_valid = 1'b0;
    logic        signed_mode = 1'b0;
    logic        out_ready = 1'b0;
    logic        sel = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    logic        in_valid8, in_ready8, out_valid8, dz8, ov8;
    logic [7:0]  q8, r8;
    logic        in_valid16, in_ready16, out_valid16, dz16, ov16;
    logic [15:0] q16, r16;

    logic        m_in_ready, m_out_valid, m_dz, m_ov;
    logic [15:0] m_q, m_r;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    assign in_valid8   = in_valid & ~sel;
    assign in_valid16  = in_valid & sel;
    assign m_in_ready  = sel ? in_ready16  : in_ready8;
    assign m_out_valid = sel ? out_valid16 : out_valid8;
    assign m_q         = sel ? q16 : {8'h00, q8};
    assign m_r         = sel ? r16 : {8'h00, r8};
    assign m_dz        = sel ? dz16 : dz8;
    assign m_ov        = sel ? ov16 : ov8;

    seq_divider_param #(.W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_valid(in_valid8), .in_ready(in_ready8), .signed_mode(signed_mode),
        .dividend(a[7:0]), .divisor(b[7:0]),
        .out_valid(out_valid8), .out_ready(out_ready),
        .quotient(q8), .remainder(r8), .div_by_zero(dz8), .overflow(ov8)
    );

    seq_divider_param #(.W(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_valid(in_valid16), .in_ready(in_ready16), .signed_mode(signed_mode),
        .dividend(a), .divisor(b),
        .out_valid(out_valid16), .out_ready(out_ready),
        .quotient(q16), .remainder(r16), .div_by_zero(dz16), .overflow(ov16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic sm, input logic [15:0] x,
                                   input logic [15:0] y, input int w);
        longint mask, xs, ys, qq, rr;
        exp_t   e;
        mask = (longint'(1) << w) - 1;
        e.dz = 1'b0;
        e.ov = 1'b0;
        if (y == 16'h0000) begin
            qq   = mask;
            rr   = longint'(x);
            e.dz = 1'b1;
        end else if (sm) begin
            xs = longint'(x);
            ys = longint'(y);
            if (x[w-1]) xs = xs - (longint'(1) << w);
            if (y[w-1]) ys = ys - (longint'(1) << w);
            qq   = xs / ys;
            rr   = xs % ys;
            e.ov = (xs == -(longint'(1) << (w - 1))) && (ys == -1);
        end else begin
            qq = longint'(x) / longint'(y);
            rr = longint'(x) % longint'(y);
        end
        e.q = 16'(qq & mask);
        e.r = 16'(rr & mask);
        return e;
    endfunction

    // One full transaction; stall_at >= 0 drops ena for 3 cycles from that point
    task automatic run(input logic sm, input logic [15:0] xi, input logic [15:0] yi,
                       input int stall_at, input int hold);
        exp_t        e;
        logic [15:0] x, y;
        int          lat, w, explat;
        logic        busy_ok;
        x = sel ? xi : (xi & 16'h00FF);
        y = sel ? yi : (yi & 16'h00FF);
        w = sel ? 16 : 8;
        sb.push_back(model(sm, x, y, w));
        explat = (y == 16'h0000) ? 2 : w + 1;
        if (stall_at >= 0) explat += 3;

        @(negedge clk);
        signed_mode = sm;
        a = x;
        b = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        signed_mode = ~sm;
        a = 16'($urandom);
        b = 16'($urandom);

        lat = 0;
        busy_ok = 1'b1;
        while (!m_out_valid && lat < 60) begin
            ena = !(stall_at >= 0 && lat >= stall_at && lat < stall_at + 3);
            @(posedge clk);
            #1;
            lat++;
            if (!m_out_valid && m_in_ready) busy_ok = 1'b0;
        end
        ena = 1'b1;
        check("latency", lat, explat);
        check("busy_ready", busy_ok, 1);

        e = sb.pop_front();
        check("quotient", m_q, e.q);
        check("remainder", m_r, e.r);
        check("div_by_zero", m_dz, e.dz);
        check("overflow", m_ov, e.ov);

        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = 16'($urandom);
            b = 16'($urandom);
            @(posedge clk);
            #1;
            check("hold_valid", m_out_valid, 1);
            check("hold_q", m_q, e.q);
            check("hold_r", m_r, e.r);
            check("hold_ready", m_in_ready, 0);
        end
        in_valid = 1'b0;

        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_ready", m_in_ready, 1);
        check("release_valid", m_out_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic quiet;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid8, 0);
        check("rst_q", q8, 0);
        check("rst_r", r8, 0);
        check("rst_dz", dz8, 0);
        check("rst_ov", ov8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready8", in_ready8, 1);
        check("rst_ready16", in_ready16, 1);

        sel = 1'b0;
        run(1'b0, 16'd200, 16'd7, -1, 0);
        run(1'b1, 16'h009C, 16'h0007, -1, 0);
        run(1'b1, 16'h0064, 16'h00F9, -1, 0);
        run(1'b1, 16'h009C, 16'h00F9, -1, 0);
        run(1'b0, 16'h0037, 16'h0000, -1, 0);
        run(1'b1, 16'h0037, 16'h0000, -1, 0);
        run(1'b1, 16'h0080, 16'h00FF, -1, 0);
        run(1'b0, 16'h0080, 16'h00FF, -1, 0);
        run(1'b0, 16'd250, 16'd9, -1, 5);
        run(1'b1, 16'h00B3, 16'h0005, 3, 0);
        for (int i = 0; i < 20; i++) begin
            run(1'($urandom), 16'($urandom),
                ((i % 7) == 0) ? 16'h0000 : 16'($urandom), -1, 0);
        end

        // Abort mid-calculation with an asynchronous reset between edges
        @(negedge clk);
        signed_mode = 1'b0;
        a = 16'd200;
        b = 16'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_valid", out_valid8, 0);
        check("abort_q", q8, 0);
        check("abort_r", r8, 0);
        check("abort_dz", dz8, 0);
        check("abort_ov", ov8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_ready", in_ready8, 1);
        quiet = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid8) quiet = 1'b0;
        end
        check("abort_no_result", quiet, 1);

        sel = 1'b1;
        run(1'b0, 16'd65535, 16'd255, -1, 0);
        run(1'b1, 16'h8000, 16'hFFFF, -1, 0);
        run(1'b1, 16'hD8F1, 16'h0013, -1, 0);
        run(1'b0, 16'h1234, 16'h0000, -1, 0);
        for (int i = 0; i < 5; i++) begin
            run(1'($urandom), 16'($urandom), 16'($urandom), -1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
